// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG parse sequencer and its bit-buffer.
package ecg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_DECODE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } ecg_state_t;

    localparam logic kEcXfm      = 1'b1;
    localparam logic kEcBP       = 1'b0;
    localparam int   kCoeffW     = 9;
    localparam int   kMaxSamples = 7;
    localparam int   kWinW       = 128;
    localparam int   kCoeffBusW  = kCoeffW * kMaxSamples;

    // Samples carried by each ECG: transform mode grows 1,3,5,7; BP mode is flat 4.
    function automatic logic [2:0] ec_num_sample_f(input logic mode, input logic [1:0] idx);
        logic [2:0] n;
        n = 3'd4;
        if (mode == kEcXfm) begin
            case (idx)
                2'd0:    n = 3'd1;
                2'd1:    n = 3'd3;
                2'd2:    n = 3'd5;
                default: n = 3'd7;
            endcase
        end else if (mode == kEcBP) begin
            n = 3'd4;
        end
        return n;
    endfunction

endpackage

// File: rtl/ecg_bitbuf.sv
// Left-aligned bitstream buffer: consume from the top, append words just below the valid bits.
module ecg_bitbuf
    import ecg_pkg::*;
#(
    parameter int BUF_W  = 256,
    parameter int WORD_W = 64,
    parameter int LVL_W  = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [7:0]        consume_n,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic [kWinW-1:0]  win,
    output logic [LVL_W-1:0]  lvl
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [BUF_W-1:0] base_buf, word_pos;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [LVL_W-1:0] base_lvl;
    logic             take;

    // Bits below the level are kept zero so an appended word can simply be OR-ed in.
    always_comb begin
        bs_ready = (lvl_q <= LVL_W'(BUF_W - WORD_W));
        take     = bs_valid && bs_ready;
        base_buf = flush ? '0 : (buf_q << consume_n);
        base_lvl = flush ? '0 : (lvl_q - LVL_W'(consume_n));
        word_pos = {bs_data, {(BUF_W - WORD_W){1'b0}}} >> base_lvl;
        buf_d    = base_buf;
        lvl_d    = base_lvl;
        if (take) begin
            buf_d = base_buf | word_pos;
            lvl_d = base_lvl + LVL_W'(WORD_W);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            lvl_q <= '0;
        end else begin
            buf_q <= buf_d;
            lvl_q <= lvl_d;
        end
    end

    assign win = buf_q[BUF_W-1 -: kWinW];
    assign lvl = lvl_q;

endmodule

// File: rtl/ecg_parse_seq.sv
// ECG parse sequencer: feeds a 128-bit window to an external decoder and emits one group per ECG.
// Optional consumed-bit counter output enabled by ECG_BITCOUNT_EN.
module ecg_parse_seq
    import ecg_pkg::*;
#(
    parameter int NUM_ECG = 4,
    parameter int WORD_W  = 64,
    parameter int BUF_W   = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode_xfm,
    input  logic                          flush,
    output logic                          busy,
    input  logic [WORD_W-1:0]             bs_data,
    input  logic                          bs_valid,
    output logic                          bs_ready,
    output logic [kWinW-1:0]              win,
    output logic [1:0]                    ecg_sel,
    output logic [2:0]                    ec_num_sample,
    input  logic [7:0]                    dec_numbits,
    input  logic [kCoeffBusW-1:0]         dec_coeff,
    input  logic [kMaxSamples-1:0]        dec_sign_valid,
    output logic                          grp_valid,
    input  logic                          grp_ready,
    output logic [1:0]                    grp_idx,
    output logic [kCoeffBusW-1:0]         grp_coeff,
    output logic [kMaxSamples-1:0]        grp_sign_valid,
    output logic [7:0]                    grp_numbits,
    output logic                          blk_done,
    output logic                          err,
`ifdef ECG_BITCOUNT_EN
    output logic [15:0]                   bit_count,
`endif
    output ecg_state_t                    dbg_state,
    output logic [$clog2(BUF_W+1)-1:0]    dbg_lvl
);

    localparam int               LVL_W       = $clog2(BUF_W + 1);
    localparam logic [1:0]       LAST_IDX    = 2'(NUM_ECG - 1);
    localparam logic [LVL_W-1:0] WIN_LVL     = LVL_W'(kWinW);
    localparam logic [7:0]       MAX_NUMBITS = 8'(kWinW);

    ecg_state_t                state_q, state_d;
    logic                      mode_q, mode_d;
    logic [1:0]                ecg_sel_q, ecg_sel_d;
    logic [1:0]                grp_idx_q, grp_idx_d;
    logic [kCoeffBusW-1:0]     grp_coeff_q, grp_coeff_d;
    logic [kMaxSamples-1:0]    grp_sign_q, grp_sign_d;
    logic [7:0]                grp_numbits_q, grp_numbits_d;
    logic                      err_q, err_d;

    logic                      start_acc;
    logic                      flush_en;
    logic                      numbits_ok;
    logic [7:0]                consume_n;
    logic [LVL_W-1:0]          lvl;

    ecg_bitbuf #(
        .BUF_W  (BUF_W),
        .WORD_W (WORD_W),
        .LVL_W  (LVL_W)
    ) u_bitbuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_en),
        .consume_n (consume_n),
        .bs_data   (bs_data),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .win       (win),
        .lvl       (lvl)
    );

    assign numbits_ok = (dec_numbits != 8'd0) && (dec_numbits <= MAX_NUMBITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Group handshake: a group transfers on the cycle grp_valid && grp_ready; grp_valid never
    // drops and grp_* never change until that transfer happens.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FILL;
            ST_FILL:   if (lvl >= WIN_LVL) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_HOLD;
            ST_HOLD:   if (grp_ready) state_d = (grp_idx_q == LAST_IDX) ? ST_DONE : ST_FILL;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        grp_valid     = (state_q == ST_HOLD);
        blk_done      = (state_q == ST_DONE);
        start_acc     = (state_q == ST_IDLE) && start;
        flush_en      = (state_q == ST_IDLE) && flush;
        consume_n     = ((state_q == ST_DECODE) && numbits_ok) ? dec_numbits : 8'd0;
        ec_num_sample = (state_q == ST_IDLE) ? 3'd0 : ec_num_sample_f(mode_q, ecg_sel_q);
    end

    // An illegal numbits still produces a group; only the consume is suppressed.
    always_comb begin
        mode_d        = mode_q;
        ecg_sel_d     = ecg_sel_q;
        grp_idx_d     = grp_idx_q;
        grp_coeff_d   = grp_coeff_q;
        grp_sign_d    = grp_sign_q;
        grp_numbits_d = grp_numbits_q;
        err_d         = err_q;
        if (start_acc) begin
            mode_d    = mode_xfm;
            ecg_sel_d = 2'd0;
            err_d     = 1'b0;
        end
        if (state_q == ST_DECODE) begin
            grp_idx_d     = ecg_sel_q;
            grp_coeff_d   = dec_coeff;
            grp_sign_d    = dec_sign_valid;
            grp_numbits_d = dec_numbits;
            err_d         = err_q | ~numbits_ok;
        end
        if ((state_q == ST_HOLD) && grp_ready && (grp_idx_q != LAST_IDX)) begin
            ecg_sel_d = ecg_sel_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= 1'b0;
            ecg_sel_q     <= 2'd0;
            grp_idx_q     <= 2'd0;
            grp_coeff_q   <= '0;
            grp_sign_q    <= '0;
            grp_numbits_q <= 8'd0;
            err_q         <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            ecg_sel_q     <= ecg_sel_d;
            grp_idx_q     <= grp_idx_d;
            grp_coeff_q   <= grp_coeff_d;
            grp_sign_q    <= grp_sign_d;
            grp_numbits_q <= grp_numbits_d;
            err_q         <= err_d;
        end
    end

`ifdef ECG_BITCOUNT_EN
    logic [15:0] bit_count_q, bit_count_d;

    always_comb begin
        bit_count_d = bit_count_q;
        if (start_acc) begin
            bit_count_d = 16'd0;
        end else if (state_q == ST_DECODE) begin
            bit_count_d = bit_count_q + 16'(consume_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count_q <= 16'd0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`else
    // Without the counter the consumed-bit total is simply not tracked.
`endif

    assign ecg_sel        = ecg_sel_q;
    assign grp_idx        = grp_idx_q;
    assign grp_coeff      = grp_coeff_q;
    assign grp_sign_valid = grp_sign_q;
    assign grp_numbits    = grp_numbits_q;
    assign err            = err_q;
    assign dbg_state      = state_q;
    assign dbg_lvl        = lvl;

endmodule

// File: tb/tb_ecg_parse_seq.sv
// Directed bench for ecg_parse_seq: a bit-queue model of the bitstream gives expected window/level.
module tb_ecg_parse_seq;
  import ecg_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode_xfm = 1'b0;
  logic         flush = 1'b0;
  logic         busy;
  logic [63:0]  bs_data = '0;
  logic         bs_valid = 1'b0;
  logic         bs_ready;
  logic [127:0] win;
  logic [1:0]   ecg_sel;
  logic [2:0]   ec_num_sample;
  logic [7:0]   dec_numbits;
  logic [62:0]  dec_coeff;
  logic [6:0]   dec_sign_valid;
  logic         grp_valid;
  logic         grp_ready = 1'b0;
  logic [1:0]   grp_idx;
  logic [62:0]  grp_coeff;
  logic [6:0]   grp_sign_valid;
  logic [7:0]   grp_numbits;
  logic         blk_done;
  logic         err;
`ifdef ECG_BITCOUNT_EN
  logic [15:0]  bit_count;
`endif
  ecg_state_t   dbg_state;
  logic [8:0]   dbg_lvl;

  int errors = 0;
  int checks = 0;
  logic [7:0]  nb_tab [4];
  logic [15:0] salt = 16'h1357;
  logic        exp_q[$];

  ecg_parse_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode_xfm(mode_xfm), .flush(flush), .busy(busy),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready), .win(win),
    .ecg_sel(ecg_sel), .ec_num_sample(ec_num_sample), .dec_numbits(dec_numbits),
    .dec_coeff(dec_coeff), .dec_sign_valid(dec_sign_valid), .grp_valid(grp_valid),
    .grp_ready(grp_ready), .grp_idx(grp_idx), .grp_coeff(grp_coeff),
    .grp_sign_valid(grp_sign_valid), .grp_numbits(grp_numbits), .blk_done(blk_done),
    .err(err),
`ifdef ECG_BITCOUNT_EN
    .bit_count(bit_count),
`endif
    .dbg_state(dbg_state), .dbg_lvl(dbg_lvl)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // decoder model: per-ECG numbits table, coefficients derived from index and salt
  function automatic logic [62:0] coeff_pat(input logic [1:0] g, input logic [15:0] s);
    return {s[14:0], 16'hA5C3 ^ {14'b0, g}, ~s, s};
  endfunction

  function automatic logic [6:0] sign_pat(input logic [1:0] g);
    return 7'h2A ^ {5'b0, g};
  endfunction

  assign dec_numbits    = nb_tab[ecg_sel];
  assign dec_coeff      = coeff_pat(ecg_sel, salt);
  assign dec_sign_valid = sign_pat(ecg_sel);

  // scoreboard
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic pop_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) b = exp_q.pop_front();
  endtask

  function automatic logic [127:0] model_win();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 128 && i < exp_q.size(); i++) w[127-i] = exp_q[i];
    return w;
  endfunction

  // drivers
  task automatic send_word(input logic [63:0] w);
    int n;
    n = 0;
    bs_data  = w;
    bs_valid = 1'b1;
    while (!bs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bs_ready_wait", bs_ready, 1'b1);
    @(negedge clk);
    bs_valid = 1'b0;
    push_word(w);
  endtask

  task automatic do_start(input logic m);
    mode_xfm = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic run_group(input logic [1:0] g, input logic [2:0] ns, input int hold);
    int           n;
    logic [7:0]   nb;
    logic [62:0]  cf;
    logic [127:0] w;
    int           lv;
    n = 0;
    while (!grp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("grp_valid_wait", grp_valid, 1'b1);
    nb = nb_tab[g];
    pop_bits((nb == 8'd0 || nb > 8'd128) ? 0 : int'(nb));
    cf = coeff_pat(g, salt);
    w  = model_win();
    lv = exp_q.size();
    chk("grp_idx", grp_idx, g);
    chk("ecg_sel", ecg_sel, g);
    chk("ec_num_sample", ec_num_sample, ns);
    chk("grp_numbits", grp_numbits, nb);
    chk("grp_coeff", grp_coeff, cf);
    chk("grp_sign_valid", grp_sign_valid, sign_pat(g));
    chk("grp_lvl", dbg_lvl, lv);
    chk("grp_busy", busy, 1'b1);
    chk("grp_blk_done", blk_done, 1'b0);
    if (lv >= 128) chk("grp_win", win, w);
    for (int c = 0; c < hold; c++) begin
      salt = salt + 16'h0101;
      @(negedge clk);
      chk("hold_valid", grp_valid, 1'b1);
      chk("hold_idx", grp_idx, g);
      chk("hold_ecg_sel", ecg_sel, g);
      chk("hold_coeff", grp_coeff, cf);
      chk("hold_numbits", grp_numbits, nb);
      chk("hold_win", win, w);
      chk("hold_lvl", dbg_lvl, lv);
    end
    grp_ready = 1'b1;
    @(negedge clk);
    grp_ready = 1'b0;
  endtask

  task automatic wait_state(input ecg_state_t s);
    int n;
    n = 0;
    while (dbg_state != s && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("state_wait", dbg_state, s);
  endtask

  // directed sequence
  initial begin
    logic [63:0] wtab [4];
    logic [63:0] xw;
    wtab = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'hA5A5_5A5A_C3C3_3C3C, 64'h0F0F_F0F0_1234_8765};
    xw = 64'hBEEF_0000_1111_2222;
    nb_tab = '{8'd1, 8'd13, 8'd21, 8'd29};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bs_ready", bs_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grp_valid", grp_valid, 1'b0);
    chk("rst_lvl", dbg_lvl, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_ec_num_sample", ec_num_sample, 3'd0);
    chk("rst_win", win, 128'd0);
    chk("rst_state", dbg_state, ST_IDLE);

    // reset in the middle of a fill
    send_word(64'hDEAD_BEEF_0123_4567);
    chk("fill_lvl64", dbg_lvl, 64);
    do_start(kEcXfm);
    chk("fill_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_lvl", dbg_lvl, 0);
    chk("midrst_grp_valid", grp_valid, 1'b0);
    chk("midrst_bs_ready", bs_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_no_done", blk_done, 1'b0);

    // XFM block, four words, numbits 1/13/21/29
    for (int i = 0; i < 4; i++) send_word(wtab[i]);
    chk("full_lvl", dbg_lvl, 256);
    chk("full_bs_ready", bs_ready, 1'b0);
    do_start(kEcXfm);
    run_group(2'd0, 3'd1, 0);
    run_group(2'd1, 3'd3, 0);
    run_group(2'd2, 3'd5, 0);
    run_group(2'd3, 3'd7, 0);
    chk("xfm_blk_done", blk_done, 1'b1);
    @(negedge clk);
    chk("xfm_done_pulse", blk_done, 1'b0);
    chk("xfm_busy_clear", busy, 1'b0);
    chk("xfm_lvl", dbg_lvl, 192);
    chk("xfm_win", win, {wtab[1], wtab[2]});

    // BP block with backpressure on group 2
    nb_tab = '{8'd8, 8'd8, 8'd8, 8'd8};
    do_start(kEcBP);
    run_group(2'd0, 3'd4, 0);
    run_group(2'd1, 3'd4, 0);
    run_group(2'd2, 3'd4, 5);
    run_group(2'd3, 3'd4, 0);
    chk("bp_blk_done", blk_done, 1'b1);
    @(negedge clk);
    chk("bp_lvl", dbg_lvl, 160);

    // flush, then underflow: one word is not enough to decode
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    chk("flush_lvl", dbg_lvl, 0);
    nb_tab = '{8'd16, 8'd16, 8'd16, 8'd16};
    do_start(kEcBP);
    send_word(64'h1111_2222_3333_4444);
    repeat (5) @(negedge clk);
    chk("uf_no_valid", grp_valid, 1'b0);
    chk("uf_state_fill", dbg_state, ST_FILL);
    send_word(64'h5555_6666_7777_8888);
    chk("uf_valid_c0", grp_valid, 1'b0);
    @(negedge clk);
    chk("uf_valid_c1", grp_valid, 1'b0);
    @(negedge clk);
    chk("uf_valid_c2", grp_valid, 1'b1);
    run_group(2'd0, 3'd4, 0);
    send_word(64'h9999_AAAA_BBBB_CCCC);
    send_word(64'hDDDD_EEEE_FFFF_0000);
    run_group(2'd1, 3'd4, 0);
    run_group(2'd2, 3'd4, 0);
    run_group(2'd3, 3'd4, 0);
    chk("uf_blk_done", blk_done, 1'b1);
    @(negedge clk);
    chk("uf_lvl", dbg_lvl, 192);

    // word arrives in the same cycle as a 20-bit consume at level 192
    nb_tab = '{8'd20, 8'd20, 8'd20, 8'd20};
    salt = 16'h2468;
    do_start(kEcBP);
    wait_state(ST_DECODE);
    bs_data  = xw;
    bs_valid = 1'b1;
    @(negedge clk);
    bs_valid = 1'b0;
    push_word(xw);
    chk("sim_lvl236", dbg_lvl, 236);
    run_group(2'd0, 3'd4, 0);
    run_group(2'd1, 3'd4, 0);
    run_group(2'd2, 3'd4, 0);
    run_group(2'd3, 3'd4, 0);
    @(negedge clk);
    chk("sim_lvl176", dbg_lvl, 176);
    // word MSB was placed at bit 83; 60 more bits consumed puts it at bit 143 (win[15])
    chk("sim_word_pos", win[15:0], xw[63:48]);

    // numbits 0 sets err, consumes nothing, group still delivered
    nb_tab = '{8'd0, 8'd10, 8'd10, 8'd10};
    do_start(kEcBP);
    run_group(2'd0, 3'd4, 0);
    chk("zero_err", err, 1'b1);
    run_group(2'd1, 3'd4, 0);
    run_group(2'd2, 3'd4, 0);
    run_group(2'd3, 3'd4, 0);
    @(negedge clk);
    chk("zero_err_sticky", err, 1'b1);
    chk("zero_lvl", dbg_lvl, 146);

    // next start clears err; numbits 129 is illegal too
    send_word(64'h0A0B_0C0D_0E0F_1011);
    nb_tab = '{8'd10, 8'd10, 8'd10, 8'd129};
    do_start(kEcBP);
    chk("start_clears_err", err, 1'b0);
    run_group(2'd0, 3'd4, 0);
    run_group(2'd1, 3'd4, 0);
    run_group(2'd2, 3'd4, 0);
    chk("legal_err_low", err, 1'b0);
    run_group(2'd3, 3'd4, 0);
    chk("over_err", err, 1'b1);
    @(negedge clk);
    chk("over_lvl", dbg_lvl, 180);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
